mmio_port_responder: RTL and testbench

- Memory-mapped I/O responder on the processor's data-bus side.
- Serves processor loads and stores to the PortOut and PortIn register window.
- Drives the 32-bit output port and synchronizes the 8-bit input port.
- Captures input-change events into a small FIFO that the processor drains by reading a pop register.

---
 rtl/mmio_port_responder_pkg.sv | 23 ++
 rtl/mmio_port_responder_if.sv | 22 ++
 rtl/mmio_port_responder_port_event_fifo.sv | 61 ++++++
 rtl/mmio_port_responder.sv | 164 ++++++++++++++++
 tb/tb_mmio_port_responder.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/mmio_port_responder_pkg.sv
// rtl/mmio_port_responder_pkg.sv - shared constants and types for the MMIO port responder
// Purpose: register word offsets, EVT_STATUS bit positions and the event-entry type.
package mmio_port_responder_pkg;

  // Register word offsets (Address[4:2])
  localparam logic [2:0] OFF_PORT_OUT   = 3'd0;
  localparam logic [2:0] OFF_PORT_IN    = 3'd1;
  localparam logic [2:0] OFF_EVT_STATUS = 3'd2;
  localparam logic [2:0] OFF_EVT_POP    = 3'd3;
  localparam logic [2:0] OFF_EVT_CTRL   = 3'd4;

  // EVT_STATUS bit positions
  localparam int ST_NOT_EMPTY = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_OVERFLOW  = 2;
  localparam int ST_COUNT_LSB = 4;
  localparam int ST_COUNT_W   = 4;

  // Event entry: {snapshot[7:0], changed[7:0]}
  localparam int EVT_W = 16;
  typedef logic [EVT_W-1:0] evt_t;

endpackage

// File: rtl/mmio_port_responder_if.sv
// rtl/mmio_port_responder_if.sv - processor data-bus interface for the MMIO port responder
// Purpose: groups the load/store bus signals.
// Signals: Address, MemWrite, MemRead, WriteData (processor -> responder),
//          ReadData, ReadValid (responder -> processor).
interface mmio_port_responder_if;
  logic [31:0] Address;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        ReadValid;

  modport master (
    output Address, MemWrite, MemRead, WriteData,
    input  ReadData, ReadValid
  );

  modport slave (
    input  Address, MemWrite, MemRead, WriteData,
    output ReadData, ReadValid
  );
endinterface

// File: rtl/mmio_port_responder_port_event_fifo.sv
// rtl/mmio_port_responder_port_event_fifo.sv - input-change event FIFO
// Purpose: DEPTH-entry FIFO of event entries, pointers wrap modulo DEPTH.
// Ports: clk, reset (async active-low), i_push/i_data, i_pop,
//        o_head (valid when !o_empty), o_full, o_empty, o_count (0..DEPTH).
module port_event_fifo
  import mmio_port_responder_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_push,
  input  evt_t          i_data,
  input  logic          i_pop,
  output evt_t          o_head,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count
);
  localparam int AW = $clog2(DEPTH);

  evt_t          r_mem [DEPTH];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic          w_do_pop;
  logic          w_do_push;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_count = r_count;
  assign o_head  = r_mem[r_head];

  // A pop frees a slot in the same edge, so a full FIFO still accepts a push then.
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) begin
        r_tail <= r_tail + 1'b1;
      end
      if (w_do_pop) begin
        r_head <= r_head + 1'b1;
      end
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

  // Storage needs no reset: the head is only consumed while non-empty.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_tail] <= i_data;
    end
  end
endmodule

// File: rtl/mmio_port_responder.sv
// rtl/mmio_port_responder.sv - MMIO responder for PortOut/PortIn and input-change events
// Purpose: serves loads/stores to a 5-word window at BASE_ADDR, drives PortOut,
//          synchronizes PortIn and queues input-change events for the processor.
// Ports: clk, reset (async active-low), bus (slave side of the data bus),
//        PortIn (async 8-bit input), PortOut (32-bit output register), Irq.
// Build option: PORT_IRQ_EN - when defined, Irq is registered (not_empty | overflow);
//               otherwise Irq is tied low.
module mmio_port_responder
  import mmio_port_responder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h1001_0040,
  parameter int          FIFO_DEPTH  = 4,
  parameter int          SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  mmio_port_responder_if.slave    bus,
  input  logic [7:0]              PortIn,
  output logic [31:0]             PortOut,
  output logic                    Irq
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [31:0]   r_port_out;
  logic [31:0]   r_rdata;
  logic          r_rvalid;
  logic [7:0]    r_sync [SYNC_STAGES];
  logic [7:0]    r_prev;
  logic [7:0]    r_mask;
  logic          r_overflow;

  logic [2:0]    w_off;
  logic          w_hit;
  logic          w_wr;
  logic          w_rd;
  logic [7:0]    w_sync;
  logic [7:0]    w_changed;
  logic          w_push;
  logic          w_pop;
  logic          w_drop;
  logic          w_ovf_clear;
  evt_t          w_head;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;
  logic [31:0]   w_status;
  logic [31:0]   w_rmux;
  logic          w_unused;

  // Byte lane bits are not decoded.
  assign w_unused = ^bus.Address[1:0];

  assign w_off = bus.Address[4:2];
  assign w_hit = (bus.Address[31:5] == BASE_ADDR[31:5]) && (w_off <= OFF_EVT_CTRL);
  assign w_wr  = bus.MemWrite && w_hit;
  // A store and load in the same cycle is treated as a store only.
  assign w_rd  = bus.MemRead && !bus.MemWrite && w_hit;

  // Input synchronizer chain followed by the previous-value register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_sync[i] <= '0;
      end
      r_prev <= '0;
    end else begin
      r_sync[0] <= PortIn;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
      r_prev <= w_sync;
    end
  end

  assign w_sync    = r_sync[SYNC_STAGES-1];
  assign w_changed = (w_sync ^ r_prev) & r_mask;
  assign w_push    = (w_changed != 8'h00);
  assign w_pop     = w_rd && (w_off == OFF_EVT_POP) && !w_empty;
  assign w_drop    = w_push && w_full && !w_pop;

  assign w_ovf_clear = w_wr && (w_off == OFF_EVT_CTRL) && bus.WriteData[0];

  port_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  ({w_sync, w_changed}),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_comb begin
    w_status = '0;
    w_status[ST_NOT_EMPTY] = !w_empty;
    w_status[ST_FULL]      = w_full;
    w_status[ST_OVERFLOW]  = r_overflow;
    w_status[ST_COUNT_LSB +: ST_COUNT_W] = ST_COUNT_W'(w_count);
  end

  always_comb begin
    w_rmux = '0;
    case (w_off)
      OFF_PORT_OUT:   w_rmux = r_port_out;
      OFF_PORT_IN:    w_rmux = {24'h0, w_sync};
      OFF_EVT_STATUS: w_rmux = w_status;
      OFF_EVT_POP:    w_rmux = w_empty ? 32'h0 : {16'h0, w_head};
      OFF_EVT_CTRL:   w_rmux = {16'h0, r_mask, 8'h00};
      default:        w_rmux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_port_out <= '0;
      r_mask     <= 8'hFF;
      r_overflow <= 1'b0;
      r_rdata    <= '0;
      r_rvalid   <= 1'b0;
    end else begin
      if (w_wr && (w_off == OFF_PORT_OUT)) begin
        r_port_out <= bus.WriteData;
      end
      if (w_wr && (w_off == OFF_EVT_CTRL)) begin
        r_mask <= bus.WriteData[15:8];
      end
      // A drop in the same edge as a clear leaves overflow set.
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (w_ovf_clear) begin
        r_overflow <= 1'b0;
      end
      if (w_rd) begin
        r_rdata <= w_rmux;
      end
      r_rvalid <= w_rd;
    end
  end

  assign bus.ReadData  = r_rdata;
  assign bus.ReadValid = r_rvalid;
  assign PortOut       = r_port_out;

`ifdef PORT_IRQ_EN
  logic r_irq;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= !w_empty || r_overflow;
    end
  end

  assign Irq = r_irq;
`else
  assign Irq = 1'b0;
`endif
endmodule

// File: tb/tb_mmio_port_responder.sv
// tb/tb_mmio_port_responder.sv - directed vector bench for mmio_port_responder
module tb_mmio_port_responder;
  localparam logic [31:0] B = 32'h1001_0040;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [7:0]  pin;
    logic        exp_rv;
    logic [31:0] exp_rd;
    logic [31:0] exp_po;
  } vec_t;

  logic        clk;
  logic        reset;
  logic [7:0]  PortIn;
  logic [31:0] PortOut;
  logic        Irq;
  int          n_vec;
  int          n_bad;
  logic [31:0] last_rd;
  logic        exp_irq_on;
  vec_t        tv[$];

  mmio_port_responder_if bus();

  mmio_port_responder dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus.slave),
    .PortIn  (PortIn),
    .PortOut (PortOut),
    .Irq     (Irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t V(input logic wr, input logic rd, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [7:0] pin,
                             input logic rv, input logic [31:0] rdx, input logic [31:0] po);
    vec_t v;
    v.wr = wr; v.rd = rd; v.addr = addr; v.wdata = wdata; v.pin = pin;
    v.exp_rv = rv; v.exp_rd = rdx; v.exp_po = po;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    bus.MemWrite  = v.wr;
    bus.MemRead   = v.rd;
    bus.Address   = v.addr;
    bus.WriteData = v.wdata;
    PortIn        = v.pin;
    @(posedge clk);
    #1;
    if (v.exp_rv) last_rd = v.exp_rd;
    check({tag, " ReadValid"}, {31'h0, bus.ReadValid}, {31'h0, v.exp_rv});
    check({tag, " ReadData"}, bus.ReadData, last_rd);
    check({tag, " PortOut"}, PortOut, v.exp_po);
  endtask

  initial begin
    logic [31:0] P;
    n_vec = 0;
    n_bad = 0;
    last_rd = 32'h0;
`ifdef PORT_IRQ_EN
    exp_irq_on = 1'b1;
`else
    exp_irq_on = 1'b0;
`endif
    P = 32'h1234_5678;

    // wr, rd, addr, wdata, pin, exp_rv, exp_rd, exp_po
    tv.push_back(V(1, 0, B,          32'hDEADBEEF, 8'h00, 0, 0,            32'hDEADBEEF));
    tv.push_back(V(0, 1, B,          0,            8'h00, 1, 32'hDEADBEEF, 32'hDEADBEEF));
    tv.push_back(V(0, 0, 0,          0,            8'h00, 0, 0,            32'hDEADBEEF));
    tv.push_back(V(0, 1, B + 3,      0,            8'h00, 1, 32'hDEADBEEF, 32'hDEADBEEF));
    tv.push_back(V(0, 1, B + 32'h14, 0,            8'h00, 0, 0,            32'hDEADBEEF));
    tv.push_back(V(1, 0, B + 32'h20, 1,            8'h00, 0, 0,            32'hDEADBEEF));
    tv.push_back(V(1, 1, B,          P,            8'h00, 0, 0,            P));
    tv.push_back(V(0, 0, 0,          0,            8'h05, 0, 0,            P));
    tv.push_back(V(0, 0, 0,          0,            8'h05, 0, 0,            P));
    tv.push_back(V(0, 1, B + 4,      0,            8'h05, 1, 32'h05,       P));
    tv.push_back(V(0, 1, B + 8,      0,            8'h05, 1, 32'h11,       P));
    tv.push_back(V(0, 1, B + 12,     0,            8'h05, 1, 32'h0505,     P));
    tv.push_back(V(0, 1, B + 12,     0,            8'h05, 1, 32'h0,        P));
    tv.push_back(V(0, 1, B + 8,      0,            8'h05, 1, 32'h0,        P));
    tv.push_back(V(1, 0, B + 16,     32'h0100,     8'h05, 0, 0,            P));
    tv.push_back(V(0, 1, B + 16,     0,            8'h05, 1, 32'h0100,     P));
    for (int i = 0; i < 3; i++) tv.push_back(V(0, 0, 0, 0, 8'h07, 0, 0, P));
    tv.push_back(V(0, 1, B + 8,      0,            8'h07, 1, 32'h0,        P));
    for (int i = 0; i < 3; i++) tv.push_back(V(0, 0, 0, 0, 8'h06, 0, 0, P));
    tv.push_back(V(0, 1, B + 8,      0,            8'h06, 1, 32'h11,       P));
    tv.push_back(V(0, 1, B + 12,     0,            8'h06, 1, 32'h0601,     P));
    tv.push_back(V(0, 1, B + 8,      0,            8'h06, 1, 32'h0,        P));
    tv.push_back(V(1, 0, B + 16,     32'hFF00,     8'h06, 0, 0,            P));
    // Five back-to-back input changes into a 4-deep FIFO.
    tv.push_back(V(0, 0, 0, 0, 8'h10, 0, 0, P));
    tv.push_back(V(0, 0, 0, 0, 8'h20, 0, 0, P));
    tv.push_back(V(0, 0, 0, 0, 8'h30, 0, 0, P));
    tv.push_back(V(0, 0, 0, 0, 8'h40, 0, 0, P));
    for (int i = 0; i < 3; i++) tv.push_back(V(0, 0, 0, 0, 8'h50, 0, 0, P));
    tv.push_back(V(0, 1, B + 8,      0,            8'h50, 1, 32'h47,       P));
    tv.push_back(V(0, 1, B + 16,     0,            8'h50, 1, 32'hFF00,     P));
    tv.push_back(V(1, 0, B + 16,     32'h1,        8'h50, 0, 0,            P));
    tv.push_back(V(0, 1, B + 8,      0,            8'h50, 1, 32'h43,       P));
    tv.push_back(V(0, 1, B + 16,     0,            8'h50, 1, 32'h0,        P));
    tv.push_back(V(1, 0, B + 16,     32'hFF00,     8'h50, 0, 0,            P));
    // Full FIFO: pop and push on the same edge.
    tv.push_back(V(0, 0, 0, 0, 8'h51, 0, 0, P));
    tv.push_back(V(0, 0, 0, 0, 8'h51, 0, 0, P));
    tv.push_back(V(0, 1, B + 12,     0,            8'h51, 1, 32'h1016,     P));
    tv.push_back(V(0, 1, B + 8,      0,            8'h51, 1, 32'h43,       P));
    tv.push_back(V(0, 1, B + 12,     0,            8'h51, 1, 32'h2030,     P));
    tv.push_back(V(0, 1, B + 12,     0,            8'h51, 1, 32'h3010,     P));
    tv.push_back(V(0, 1, B + 12,     0,            8'h51, 1, 32'h4070,     P));
    tv.push_back(V(0, 1, B + 12,     0,            8'h51, 1, 32'h5101,     P));
    tv.push_back(V(0, 1, B + 8,      0,            8'h51, 1, 32'h0,        P));
    // Empty FIFO: pop returns 0 while the simultaneous push is kept.
    tv.push_back(V(0, 0, 0, 0, 8'h52, 0, 0, P));
    tv.push_back(V(0, 0, 0, 0, 8'h52, 0, 0, P));
    tv.push_back(V(0, 1, B + 12,     0,            8'h52, 1, 32'h0,        P));
    tv.push_back(V(0, 1, B + 8,      0,            8'h52, 1, 32'h11,       P));
    tv.push_back(V(0, 1, B + 12,     0,            8'h52, 1, 32'h5203,     P));
    tv.push_back(V(0, 1, B + 8,      0,            8'h52, 1, 32'h0,        P));

    reset = 1'b0;
    bus.MemWrite = 1'b0;
    bus.MemRead = 1'b0;
    bus.Address = '0;
    bus.WriteData = '0;
    PortIn = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("reset PortOut", PortOut, 32'h0);
    check("reset ReadValid", {31'h0, bus.ReadValid}, 32'h0);
    check("reset ReadData", bus.ReadData, 32'h0);
    check("reset Irq", {31'h0, Irq}, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < tv.size(); i++) begin
      apply(tv[i], $sformatf("vec%0d", i));
    end

    // Reset asserted while a read response is outstanding and MemRead stays high.
    apply(V(0, 1, B, 0, 8'h00, 1, P, P), "midread");
    #2;
    reset = 1'b0;
    #1;
    check("midreset ReadValid", {31'h0, bus.ReadValid}, 32'h0);
    check("midreset ReadData", bus.ReadData, 32'h0);
    check("midreset PortOut", PortOut, 32'h0);
    check("midreset Irq", {31'h0, Irq}, 32'h0);
    @(negedge clk);
    bus.MemRead = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    last_rd = 32'h0;
    for (int i = 0; i < 4; i++) apply(V(0, 0, 0, 0, 8'h00, 0, 0, 0), $sformatf("post%0d", i));
    apply(V(0, 1, B + 8,  0, 8'h00, 1, 32'h0,    0), "post status");
    apply(V(0, 1, B + 16, 0, 8'h00, 1, 32'hFF00, 0), "post mask");

    // Irq: push lands on the third edge, Irq follows one edge later.
    for (int e = 1; e <= 4; e++) begin
      apply(V(0, 0, 0, 0, 8'h01, 0, 0, 0), $sformatf("irq e%0d", e));
      check($sformatf("Irq edge%0d", e), {31'h0, Irq}, {31'h0, exp_irq_on && (e == 4)});
    end
    apply(V(0, 1, B + 12, 0, 8'h01, 1, 32'h0101, 0), "irq pop");
    check("Irq at pop", {31'h0, Irq}, {31'h0, exp_irq_on});
    apply(V(0, 0, 0, 0, 8'h01, 0, 0, 0), "irq after");
    check("Irq after pop", {31'h0, Irq}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
